// File: rtl/poly_small_gauss_stream.sv
// Falcon keygen small-polynomial generator: bound-checks streamed Gaussian
// samples, optionally forces an odd coefficient sum, emits n coefficients.
module poly_small_gauss_stream #(
  parameter int LOGN      = 9,
  parameter int SAMPLE_W  = 32,
  parameter int COEF_W    = 8,
  parameter int BOUND     = 127,
  parameter int PARITY_EN = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                smp_valid,
  output logic                smp_ready,
  input  logic [SAMPLE_W-1:0] smp_data,
  output logic                coef_valid,
  input  logic                coef_ready,
  output logic [COEF_W-1:0]   coef_data,
  output logic [LOGN-1:0]     coef_idx,
  output logic                coef_last,
  output logic                busy,
  output logic                done,
  output logic [15:0]         rej_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH
  } state_t;

  localparam logic [LOGN-1:0] IDX_LAST = '1;
  localparam logic [SAMPLE_W:0] BOUND_X = (SAMPLE_W+1)'(BOUND);
  localparam logic PAR_ON = (PARITY_EN != 0);

  state_t              r_state;
  logic [LOGN-1:0]     r_idx;
  logic                r_par;
  logic                r_cv;
  logic [COEF_W-1:0]   r_data;
  logic [LOGN-1:0]     r_cidx;
  logic                r_clast;
  logic                r_done;
  logic [15:0]         r_rej;

  logic [SAMPLE_W:0]   w_ext;
  logic [SAMPLE_W:0]   w_abs;
  logic                w_inb;
  logic                w_last;
  logic                w_prej;
  logic                w_sready;
  logic                w_fire;
  logic                w_acc;
  logic                w_rej;
  logic                w_out_hs;

  // one extra bit keeps |most negative sample| representable
  assign w_ext    = {smp_data[SAMPLE_W-1], smp_data};
  assign w_abs    = smp_data[SAMPLE_W-1] ? -w_ext : w_ext;
  assign w_inb    = (w_abs <= BOUND_X);
  assign w_last   = (r_idx == IDX_LAST);
  assign w_prej   = PAR_ON && w_last && !(r_par ^ smp_data[0]);
  assign w_sready = (r_state == S_RUN) && (!r_cv || coef_ready);
  assign w_fire   = smp_valid && w_sready && !abort;
  assign w_acc    = w_fire && w_inb && !w_prej;
  assign w_rej    = w_fire && !(w_inb && !w_prej);
  assign w_out_hs = r_cv && coef_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_par   <= 1'b0;
      r_cv    <= 1'b0;
      r_data  <= '0;
      r_cidx  <= '0;
      r_clast <= 1'b0;
      r_done  <= 1'b0;
      r_rej   <= '0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state <= S_IDLE;
        r_cv    <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (start) begin
              r_state <= S_RUN;
              r_idx   <= '0;
              r_par   <= 1'b0;
              r_rej   <= '0;
            end
          end
          S_RUN: begin
            if (w_out_hs)
              r_cv <= 1'b0;
            if (w_acc) begin
              r_cv    <= 1'b1;
              r_data  <= smp_data[COEF_W-1:0];
              r_cidx  <= r_idx;
              r_clast <= w_last;
              if (w_last) begin
                r_state <= S_FLUSH;
              end else begin
                r_idx <= r_idx + LOGN'(1);
                r_par <= r_par ^ smp_data[0];
              end
            end
            if (w_rej && (r_rej != 16'hFFFF))
              r_rej <= r_rej + 16'd1;
          end
          S_FLUSH: begin
            if (w_out_hs) begin
              r_cv    <= 1'b0;
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign smp_ready  = w_sready;
  assign coef_valid = r_cv;
  assign coef_data  = r_data;
  assign coef_idx   = r_cidx;
  assign coef_last  = r_clast;
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;
  assign rej_cnt    = r_rej;

endmodule
